hazard_scoreboard: RTL and testbench

- Issue/stall controller for the decode stage of the 5-stage pipeline.
- Tracks every in-flight register write from decode issue to writeback retire, with one small counter per architectural register.
- Drives hazard_detected, which the decode stage uses to zero its control word and freeze fetch.
- Also provides a drain handshake so the control path can quiesce the pipeline before a swap sequence, exception or debug halt.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_scoreboard_if.sv | 36 +++
 rtl/sb_counter.sv | 34 +++
 rtl/hazard_scoreboard.sv | 120 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and sizing for the decode-stage hazard scoreboard.
package hazard_pkg;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam int CNT_W    = 2;
    localparam int TOT_W    = 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [TOT_W-1:0]  tot_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } sb_state_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback/control bundle between the pipeline and the scoreboard.
interface hazard_scoreboard_if;
    import hazard_pkg::*;

    logic     id_valid;
    reg_idx_t id_src1;
    reg_idx_t id_src2;
    logic     id_single_src;
    logic     id_wb_en;
    reg_idx_t id_dest;
    logic     flush;
    logic     wb_commit;
    reg_idx_t wb_dest;
    logic     drain_req;
    logic     hazard_detected;
    logic     issue;
    logic     drain_ack;
    tot_t     pending_total;
    logic     err_underflow;

    modport master (
        output id_valid, id_src1, id_src2, id_single_src,
        output id_wb_en, id_dest, flush, wb_commit, wb_dest,
        output drain_req,
        input  hazard_detected, issue, drain_ack,
        input  pending_total, err_underflow
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_single_src,
        input  id_wb_en, id_dest, flush, wb_commit, wb_dest,
        input  drain_req,
        output hazard_detected, issue, drain_ack,
        output pending_total, err_underflow
    );
endinterface

// File: rtl/sb_counter.sv
// Per-register in-flight write counter; a retire at zero is reported, not applied.
module sb_counter
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_nz,
    output logic o_sat,
    output logic o_uflow
);
    localparam logic [CNT_W-1:0] ONE = 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_up;
    logic             w_dn;

    assign o_nz    = (r_cnt != '0);
    assign o_sat   = (r_cnt == CNT_MAX);
    assign o_uflow = i_dec & ~o_nz;
    assign w_up    = i_inc & ~o_sat;
    assign w_dn    = i_dec & o_nz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_up & ~w_dn) begin
            r_cnt <= r_cnt + ONE;
        end else if (w_dn & ~w_up) begin
            r_cnt <= r_cnt - ONE;
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// Decode issue/stall controller: RAW and saturation stalls plus a drain handshake.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave sb
);
    localparam tot_t TONE = 1;

    logic [NUM_REGS-1:0] w_nz;
    logic [NUM_REGS-1:0] w_sat;
    logic [NUM_REGS-1:0] w_uflow;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;

    logic      w_raw;
    logic      w_sat_hit;
    logic      w_hazard;
    logic      w_issue;
    logic      w_inc_en;
    logic      w_dec_en;
    tot_t      r_total;
    logic      r_err;
    sb_state_t r_state;
    logic      r_drain_ack;

    assign w_nz[0]    = 1'b0;
    assign w_sat[0]   = 1'b0;
    assign w_uflow[0] = 1'b0;
    assign w_inc[0]   = 1'b0;
    assign w_dec[0]   = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        assign w_inc[g] = w_inc_en & (sb.id_dest == reg_idx_t'(g));
        assign w_dec[g] = sb.wb_commit & (sb.wb_dest == reg_idx_t'(g));

        sb_counter u_cnt (
            .clk     (clk),
            .rst     (rst),
            .i_inc   (w_inc[g]),
            .i_dec   (w_dec[g]),
            .o_nz    (w_nz[g]),
            .o_sat   (w_sat[g]),
            .o_uflow (w_uflow[g])
        );
    end

    assign w_raw = ((sb.id_src1 != '0) & w_nz[sb.id_src1])
                 | (~sb.id_single_src & (sb.id_src2 != '0)
                    & w_nz[sb.id_src2]);

    assign w_sat_hit = sb.id_wb_en & (sb.id_dest != '0)
                     & w_sat[sb.id_dest];

    // Gated by rst so nothing issues while the pipeline is held in reset.
    assign w_hazard = rst & sb.id_valid
                    & (w_raw | w_sat_hit | (r_state != RUN));
    assign w_issue  = rst & sb.id_valid & ~w_hazard & ~sb.flush;

    assign w_inc_en = w_issue & sb.id_wb_en & (sb.id_dest != '0);
    assign w_dec_en = sb.wb_commit & (sb.wb_dest != '0)
                    & w_nz[sb.wb_dest];

    assign sb.hazard_detected = w_hazard;
    assign sb.issue           = w_issue;
    assign sb.drain_ack       = r_drain_ack;
    assign sb.pending_total   = r_total;
    assign sb.err_underflow   = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_total <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= r_err | (|w_uflow);
            if (w_inc_en & ~w_dec_en) begin
                r_total <= r_total + TONE;
            end else if (w_dec_en & ~w_inc_en) begin
                r_total <= r_total - TONE;
            end
        end
    end

    // Dropping drain_req wins over completion while draining.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_drain_ack <= 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    r_drain_ack <= 1'b0;
                    if (sb.drain_req) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!sb.drain_req) begin
                        r_state     <= RUN;
                        r_drain_ack <= 1'b0;
                    end else if (r_total == '0) begin
                        r_state     <= HALT;
                        r_drain_ack <= 1'b1;
                    end
                end
                HALT: begin
                    if (!sb.drain_req) begin
                        r_state     <= RUN;
                        r_drain_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= RUN;
                    r_drain_ack <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized bench for hazard_scoreboard against an array-based reference model.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    int m_cnt [NUM_REGS];
    int m_st;
    bit m_err;
    bit dr_lvl;

    hazard_scoreboard_if sb ();

    hazard_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int m_total();
        int s = 0;
        for (int r = 1; r < NUM_REGS; r++) s += m_cnt[r];
        return s;
    endfunction

    task automatic idle_inputs();
        sb.id_valid      = 1'b0;
        sb.id_src1       = '0;
        sb.id_src2       = '0;
        sb.id_single_src = 1'b0;
        sb.id_wb_en      = 1'b0;
        sb.id_dest       = '0;
        sb.flush         = 1'b0;
        sb.wb_commit     = 1'b0;
        sb.wb_dest       = '0;
        sb.drain_req     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        sb.id_valid  = 1'b1;
        sb.id_src1   = reg_idx_t'($urandom_range(0, 31));
        sb.id_wb_en  = 1'b1;
        sb.id_dest   = reg_idx_t'($urandom_range(1, 31));
        sb.drain_req = 1'($urandom_range(0, 1));
        rst = 1'b0;
        #1;
        chk("rst_hazard", int'(sb.hazard_detected), 0);
        chk("rst_issue", int'(sb.issue), 0);
        chk("rst_ack", int'(sb.drain_ack), 0);
        chk("rst_total", int'(sb.pending_total), 0);
        chk("rst_err", int'(sb.err_underflow), 0);
        for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 0;
        m_st   = 0;
        m_err  = 0;
        dr_lvl = 0;
        idle_inputs();
        rst = 1'b1;
    endtask

    // One clock: drive, compare against the model, then advance the model.
    task automatic cyc(input bit v, input int s1, input int s2,
                       input bit ss, input bit we, input int d,
                       input bit fl, input bit cm, input int wd,
                       input bit dr);
        bit raw, sat, haz, iss;
        int tot;
        @(negedge clk);
        sb.id_valid      = v;
        sb.id_src1       = reg_idx_t'(s1);
        sb.id_src2       = reg_idx_t'(s2);
        sb.id_single_src = ss;
        sb.id_wb_en      = we;
        sb.id_dest       = reg_idx_t'(d);
        sb.flush         = fl;
        sb.wb_commit     = cm;
        sb.wb_dest       = reg_idx_t'(wd);
        sb.drain_req     = dr;
        #1;
        tot = m_total();
        raw = (s1 != 0 && m_cnt[s1] > 0)
           || (!ss && s2 != 0 && m_cnt[s2] > 0);
        sat = we && d != 0 && m_cnt[d] == 3;
        haz = v && (raw || sat || m_st != 0);
        iss = v && !haz && !fl;
        chk("hazard", int'(sb.hazard_detected), int'(haz));
        chk("issue", int'(sb.issue), int'(iss));
        chk("drain_ack", int'(sb.drain_ack), int'(m_st == 2));
        chk("total", int'(sb.pending_total), tot);
        chk("err", int'(sb.err_underflow), int'(m_err));
        if (cm && wd != 0) begin
            if (m_cnt[wd] > 0) m_cnt[wd]--;
            else m_err = 1;
        end
        if (iss && we && d != 0) m_cnt[d]++;
        case (m_st)
            0: if (dr) m_st = 1;
            1: if (!dr) m_st = 0; else if (tot == 0) m_st = 2;
            default: if (!dr) m_st = 0;
        endcase
    endtask

    function automatic int pick_pending();
        int r;
        for (int k = 0; k < 8; k++) begin
            r = $urandom_range(1, 7);
            if (m_cnt[r] > 0) return r;
        end
        return $urandom_range(0, 7);
    endfunction

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        idle_inputs();
        do_reset();

        // RAW on r3; retire clears it one cycle later.
        cyc(1, 1, 2, 0, 1, 3, 0, 0, 0, 0);
        chk("tp_issue_r3", int'(sb.issue), 1);
        cyc(1, 3, 0, 1, 1, 4, 0, 0, 0, 0);
        chk("tp_raw_stall", int'(sb.hazard_detected), 1);
        cyc(1, 3, 0, 1, 1, 4, 0, 1, 3, 0);
        chk("tp_raw_same_cyc", int'(sb.hazard_detected), 1);
        cyc(1, 3, 0, 1, 1, 4, 0, 0, 0, 0);
        chk("tp_raw_release", int'(sb.issue), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);

        // r0 is never tracked.
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("tp_r0_issue", int'(sb.issue), 1);
        chk("tp_r0_total", int'(sb.pending_total), 0);

        // Saturation on r5.
        for (int i = 0; i < 3; i++) cyc(1, 1, 2, 0, 1, 5, 0, 0, 0, 0);
        cyc(1, 1, 2, 0, 1, 5, 0, 1, 5, 0);
        chk("tp_sat_stall", int'(sb.hazard_detected), 1);
        chk("tp_sat_total", int'(sb.pending_total), 3);
        cyc(1, 1, 2, 0, 1, 5, 0, 0, 0, 0);
        chk("tp_sat_release", int'(sb.issue), 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);

        // Simultaneous inc/dec on r7.
        cyc(1, 1, 2, 0, 1, 7, 0, 0, 0, 0);
        cyc(1, 1, 2, 0, 1, 7, 0, 1, 7, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("tp_incdec_total", int'(sb.pending_total), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);

        // Underflow on r9.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("tp_uflow", int'(sb.err_underflow), 1);
        chk("tp_uflow_total", int'(sb.pending_total), 0);

        // Drain with two writes in flight.
        cyc(1, 1, 2, 0, 1, 10, 0, 0, 0, 0);
        cyc(1, 1, 2, 0, 1, 11, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 2, 0, 1, 12, 0, 1, 10, 1);
        chk("tp_drain_block", int'(sb.issue), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 11, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("tp_drain_ack", int'(sb.drain_ack), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 2, 0, 1, 12, 0, 0, 0, 0);
        chk("tp_resume", int'(sb.issue), 1);

        // Random traffic with periodic mid-run resets.
        for (int n = 0; n < 4000; n++) begin
            bit cm;
            if (n % 700 == 699) do_reset();
            if ($urandom_range(0, 39) == 0) dr_lvl = ~dr_lvl;
            cm = ($urandom_range(0, 2) == 0);
            cyc(1'($urandom_range(0, 3) != 0),
                $urandom_range(0, 7), $urandom_range(0, 7),
                1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 4) != 0),
                $urandom_range(0, 7),
                1'($urandom_range(0, 7) == 0),
                cm,
                ($urandom_range(0, 15) == 0) ? $urandom_range(0, 31)
                                              : pick_pending(),
                dr_lvl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
